// File: rtl/encap_run_ctrl_if.sv
// Seed-ROM and encapsulation-core port bundle for encap_run_ctrl.
//   master (controller): drives seed_rd/seed_addr to the ROM and
//                        core_rst/seed_valid/seed to the core;
//                        receives seed_word, phase_done and core_done.
//   slave  (ROM + core): the mirror image.
interface encap_run_ctrl_if #(
  parameter int unsigned SEED_WORDS = 16,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned NPHASE     = 2
);
  localparam int unsigned AW = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1;

  logic              seed_rd;
  logic [AW-1:0]     seed_addr;
  logic [WORD_W-1:0] seed_word;
  logic              core_rst;
  logic              seed_valid;
  logic [WORD_W-1:0] seed;
  logic [NPHASE-1:0] phase_done;
  logic              core_done;

  modport master (
    output seed_rd, seed_addr, core_rst, seed_valid, seed,
    input  seed_word, phase_done, core_done
  );

  modport slave (
    input  seed_rd, seed_addr, core_rst, seed_valid, seed,
    output seed_word, phase_done, core_done
  );
endinterface

// File: rtl/encap_run_ctrl.sv
// Run controller for the McEliece encapsulation core. Per batch it runs RUNS
// encapsulations: holds the core in reset, streams SEED_WORDS seed words from a
// 1-cycle-latency ROM, and timestamps each phase_done and core_done in cycles
// counted from the first seed_valid cycle. Results are held for readout.
//   clk, rst     : clock, synchronous active-high reset
//   start        : batch start pulse (honoured only in IDLE/FIN/ERR)
//   bus          : seed ROM port and core port (encap_run_ctrl_if.master)
//   busy         : batch in progress
//   all_done     : batch finished (FIN or ERR)
//   timeout_err  : a run hit TIMEOUT (sticky until next batch)
//   run_idx      : completed runs in this batch
//   cyc_total    : last run, cycles to core_done (all-ones on timeout)
//   phase_cyc    : last run, cycles to each phase_done (all-ones if missed)
//   cyc_sum      : sum of cyc_total over the batch
//   led          : all_done & ~timeout_err
module encap_run_ctrl #(
  parameter int unsigned SEED_WORDS   = 16,
  parameter int unsigned WORD_W       = 32,
  parameter int unsigned NPHASE       = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RUNS         = 1,
  parameter int unsigned CORE_RST_CYC = 4,
  parameter int unsigned TIMEOUT      = 0,
  parameter bit          AUTO_START   = 1'b1,
  localparam int unsigned AW = (SEED_WORDS > 1) ? $clog2(SEED_WORDS) : 1,
  localparam int unsigned RW = $clog2(RUNS + 1),
  localparam int unsigned SW = CNT_W + RW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  encap_run_ctrl_if.master         bus,
  output logic                     busy,
  output logic                     all_done,
  output logic                     timeout_err,
  output logic [RW-1:0]            run_idx,
  output logic [CNT_W-1:0]         cyc_total,
  output logic [NPHASE*CNT_W-1:0]  phase_cyc,
  output logic [SW-1:0]            cyc_sum,
  output logic                     led
);
  localparam int unsigned CW = $clog2(CORE_RST_CYC + 1);

  typedef enum logic [2:0] {StIdle, StCrst, StLoad, StWait, StNext, StFin, StErr} state_e;

  state_e                  state_q, state_d;
  logic                    first_q;
  logic [CW-1:0]           crst_cnt_q, crst_cnt_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic                    seed_valid_q;
  logic                    active_q, active_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NPHASE-1:0]       cap_q, cap_d;
  logic [NPHASE*CNT_W-1:0] phase_cyc_q, phase_cyc_d;
  logic [CNT_W-1:0]        cyc_total_q, cyc_total_d;
  logic [RW-1:0]           run_idx_q, run_idx_d;
  logic [SW-1:0]           cyc_sum_q, cyc_sum_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    seed_rd, core_rst;
  logic                    in_run, done_hit, to_hit;

  // Timestamps are armed from the first seed_valid cycle until the run ends.
  assign in_run   = active_q && ((state_q == StLoad) || (state_q == StWait));
  assign done_hit = in_run && bus.core_done;
  // core_done wins if it arrives in the same cycle the limit is reached.
  assign to_hit   = (TIMEOUT != 0) && in_run && !bus.core_done &&
                    (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    crst_cnt_d    = crst_cnt_q;
    addr_d        = addr_q;
    active_d      = active_q;
    cnt_d         = cnt_q;
    cap_d         = cap_q;
    phase_cyc_d   = phase_cyc_q;
    cyc_total_d   = cyc_total_q;
    run_idx_d     = run_idx_q;
    cyc_sum_d     = cyc_sum_q;
    timeout_err_d = timeout_err_q;
    seed_rd       = 1'b0;
    core_rst      = 1'b1;

    if (active_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    if (in_run) begin
      for (int i = 0; i < int'(NPHASE); i++) begin
        if (bus.phase_done[i] && !cap_q[i]) begin
          cap_d[i]                       = 1'b1;
          phase_cyc_d[i*CNT_W +: CNT_W] = cnt_q;
        end
      end
    end

    unique case (state_q)
      StIdle, StFin, StErr: begin
        if (start || (AUTO_START && first_q && (state_q == StIdle))) begin
          run_idx_d     = '0;
          cyc_sum_d     = '0;
          timeout_err_d = 1'b0;
          crst_cnt_d    = '0;
          state_d       = StCrst;
        end
      end
      StCrst: begin
        cap_d    = '0;
        active_d = 1'b0;
        if (crst_cnt_q == CW'(CORE_RST_CYC - 1)) begin
          crst_cnt_d = '0;
          state_d    = StLoad;
        end else begin
          crst_cnt_d = crst_cnt_q + 1'b1;
        end
      end
      StLoad: begin
        core_rst = 1'b0;
        seed_rd  = 1'b1;
        // Counter reads 0 in the cycle the first seed word is presented.
        if (addr_q == '0) begin
          active_d = 1'b1;
          cnt_d    = '0;
        end
        if (addr_q == AW'(SEED_WORDS - 1)) begin
          addr_d  = '0;
          state_d = StWait;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StWait: core_rst = 1'b0;
      StNext: begin
        run_idx_d  = run_idx_q + 1'b1;
        cyc_sum_d  = cyc_sum_q + SW'(cyc_total_q);
        crst_cnt_d = '0;
        state_d    = ((32'(run_idx_q) + 32'd1) < RUNS) ? StCrst : StFin;
      end
      default: state_d = StIdle;
    endcase

    if (done_hit || to_hit) begin
      for (int i = 0; i < int'(NPHASE); i++) begin
        if (!cap_d[i]) phase_cyc_d[i*CNT_W +: CNT_W] = '1;
      end
      active_d = 1'b0;
      addr_d   = '0;
      if (done_hit) begin
        cyc_total_d = cnt_q;
        state_d     = StNext;
      end else begin
        cyc_total_d   = '1;
        timeout_err_d = 1'b1;
        state_d       = StErr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      first_q       <= 1'b1;
      crst_cnt_q    <= '0;
      addr_q        <= '0;
      seed_valid_q  <= 1'b0;
      active_q      <= 1'b0;
      cnt_q         <= '0;
      cap_q         <= '0;
      phase_cyc_q   <= '0;
      cyc_total_q   <= '0;
      run_idx_q     <= '0;
      cyc_sum_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= 1'b0;
      crst_cnt_q    <= crst_cnt_d;
      addr_q        <= addr_d;
      seed_valid_q  <= seed_rd;
      active_q      <= active_d;
      cnt_q         <= cnt_d;
      cap_q         <= cap_d;
      phase_cyc_q   <= phase_cyc_d;
      cyc_total_q   <= cyc_total_d;
      run_idx_q     <= run_idx_d;
      cyc_sum_q     <= cyc_sum_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // ROM data arrives in the seed_valid cycle; pass it straight through.
  assign bus.seed_rd    = seed_rd;
  assign bus.seed_addr  = addr_q;
  assign bus.core_rst   = core_rst;
  assign bus.seed_valid = seed_valid_q;
  assign bus.seed       = seed_valid_q ? bus.seed_word : '0;

  assign busy        = (state_q == StCrst) || (state_q == StLoad) ||
                       (state_q == StWait) || (state_q == StNext);
  assign all_done    = (state_q == StFin) || (state_q == StErr);
  assign timeout_err = timeout_err_q;
  assign run_idx     = run_idx_q;
  assign cyc_total   = cyc_total_q;
  assign phase_cyc   = phase_cyc_q;
  assign cyc_sum     = cyc_sum_q;
  assign led         = all_done && !timeout_err_q;
endmodule

// File: tb/tb_encap_run_ctrl.sv
// Bench for encap_run_ctrl. DUT a: 16 seed words, 1 run, auto start, no timeout.
// DUT b: 4 seed words, 3 runs, TIMEOUT=1000, manual start.
module tb_encap_run_ctrl;
  localparam logic [31:0] NEVER = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic a_start, b_start;
  always #5 clk = ~clk;

  encap_run_ctrl_if #(.SEED_WORDS(16), .WORD_W(32), .NPHASE(2)) a_bus ();
  encap_run_ctrl_if #(.SEED_WORDS(4),  .WORD_W(32), .NPHASE(2)) b_bus ();

  logic        a_busy, a_all_done, a_timeout_err, a_led;
  logic [0:0]  a_run_idx;
  logic [31:0] a_cyc_total;
  logic [63:0] a_phase_cyc;
  logic [32:0] a_cyc_sum;
  logic        b_busy, b_all_done, b_timeout_err, b_led;
  logic [1:0]  b_run_idx;
  logic [31:0] b_cyc_total;
  logic [63:0] b_phase_cyc;
  logic [33:0] b_cyc_sum;

  encap_run_ctrl #(.SEED_WORDS(16), .RUNS(1), .TIMEOUT(0), .AUTO_START(1'b1)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .bus(a_bus), .busy(a_busy),
    .all_done(a_all_done), .timeout_err(a_timeout_err), .run_idx(a_run_idx),
    .cyc_total(a_cyc_total), .phase_cyc(a_phase_cyc), .cyc_sum(a_cyc_sum), .led(a_led)
  );

  encap_run_ctrl #(.SEED_WORDS(4), .RUNS(3), .TIMEOUT(1000), .AUTO_START(1'b0)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .bus(b_bus), .busy(b_busy),
    .all_done(b_all_done), .timeout_err(b_timeout_err), .run_idx(b_run_idx),
    .cyc_total(b_cyc_total), .phase_cyc(b_phase_cyc), .cyc_sum(b_cyc_sum), .led(b_led)
  );

  function automatic logic [31:0] rom_word(input int unsigned i);
    return ((i + 1) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // Synchronous seed ROMs
  always @(posedge clk) if (a_bus.seed_rd) a_bus.seed_word <= rom_word(32'(a_bus.seed_addr));
  always @(posedge clk) if (b_bus.seed_rd) b_bus.seed_word <= rom_word(32'(b_bus.seed_addr));

  // Core models: count from the first seed_valid cycle (0), raise levels at thresholds.
  logic [31:0] a_p0, a_p1, a_done, b_done0, b_step;
  logic        a_act = 1'b0, b_act = 1'b0;
  logic [31:0] a_mcnt = 0, b_mcnt = 0, b_run = 0;
  logic [31:0] a_cur, b_cur;
  logic        a_on, b_on;

  always @(posedge clk) begin
    if (a_bus.core_rst) a_act <= 1'b0;
    else if (a_bus.seed_valid && !a_act) begin a_act <= 1'b1; a_mcnt <= 1; end
    else if (a_act) a_mcnt <= a_mcnt + 1;
  end
  assign a_cur = a_act ? a_mcnt : 32'd0;
  assign a_on  = a_act || a_bus.seed_valid;
  assign a_bus.phase_done = {a_on && (a_cur >= a_p1), a_on && (a_cur >= a_p0)};
  assign a_bus.core_done  = a_on && (a_cur >= a_done);

  always @(posedge clk) begin
    if (!b_busy) b_run <= 0;
    else if (b_bus.core_rst && b_act) b_run <= b_run + 1;
    if (b_bus.core_rst) b_act <= 1'b0;
    else if (b_bus.seed_valid && !b_act) begin b_act <= 1'b1; b_mcnt <= 1; end
    else if (b_act) b_mcnt <= b_mcnt + 1;
  end
  assign b_cur = b_act ? b_mcnt : 32'd0;
  assign b_on  = b_act || b_bus.seed_valid;
  assign b_bus.phase_done = 2'b00;
  assign b_bus.core_done  = b_on && (b_cur >= (b_done0 + b_step * b_run));

  // Seed stream monitor for DUT a, cleared at each batch start.
  logic [31:0] a_seen [16];
  int          a_nseen = 0, a_nrise = 0;
  logic        a_sv_prev = 1'b0, a_busy_prev = 1'b0;
  always @(negedge clk) begin
    a_sv_prev   <= a_bus.seed_valid;
    a_busy_prev <= a_busy;
    if (a_busy && !a_busy_prev) begin
      a_nseen <= 0;
      a_nrise <= 0;
    end else if (a_bus.seed_valid) begin
      if (a_nseen < 16) a_seen[a_nseen] <= a_bus.seed;
      a_nseen <= a_nseen + 1;
      if (!a_sv_prev) a_nrise <= a_nrise + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_a_done();
    int i = 0;
    while (!a_all_done && i < 3000) begin tick(); i++; end
    check("a_done_in_time", 64'(a_all_done), 64'd1);
  endtask

  task automatic wait_b_done();
    int i = 0;
    while (!b_all_done && i < 3000) begin tick(); i++; end
    check("b_done_in_time", 64'(b_all_done), 64'd1);
  endtask

  task automatic check_b_reset_vals(input string pfx);
    check({pfx, "_core_rst"},   64'(b_bus.core_rst),   64'd1);
    check({pfx, "_busy"},       64'(b_busy),           64'd0);
    check({pfx, "_all_done"},   64'(b_all_done),       64'd0);
    check({pfx, "_seed_rd"},    64'(b_bus.seed_rd),    64'd0);
    check({pfx, "_seed_valid"}, 64'(b_bus.seed_valid), 64'd0);
    check({pfx, "_seed_addr"},  64'(b_bus.seed_addr),  64'd0);
    check({pfx, "_seed"},       64'(b_bus.seed),       64'd0);
    check({pfx, "_timeout"},    64'(b_timeout_err),    64'd0);
    check({pfx, "_run_idx"},    64'(b_run_idx),        64'd0);
    check({pfx, "_cyc_total"},  64'(b_cyc_total),      64'd0);
    check({pfx, "_phase_cyc"},  b_phase_cyc,           64'd0);
    check({pfx, "_cyc_sum"},    64'(b_cyc_sum),        64'd0);
    check({pfx, "_led"},        64'(b_led),            64'd0);
  endtask

  initial begin
    int n, bad, seen, streak, nstr, s0, s1, k, tk;
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
    a_p0 = 100; a_p1 = 250; a_done = 300;
    b_done0 = NEVER; b_step = 0;
    repeat (3) tick();

    // Reset values
    check("a_rst_core_rst",  64'(a_bus.core_rst),   64'd1);
    check("a_rst_busy",      64'(a_busy),           64'd0);
    check("a_rst_all_done",  64'(a_all_done),       64'd0);
    check("a_rst_seed_rd",   64'(a_bus.seed_rd),    64'd0);
    check("a_rst_phase_cyc", a_phase_cyc,           64'd0);
    check("a_rst_cyc_total", 64'(a_cyc_total),      64'd0);
    check("a_rst_led",       64'(a_led),            64'd0);
    check_b_reset_vals("b_rst");

    // DUT a auto-starts: first post-reset cycle + 4 CRST cycles, then LOAD.
    rst = 1'b0;
    n = 0;
    while (!a_bus.seed_rd && n < 50) begin tick(); n++; end
    check("a_autostart_to_load", 64'(n), 64'd5);
    check("a_load_core_rst", 64'(a_bus.core_rst), 64'd0);
    check("a_load_busy",     64'(a_busy),         64'd1);
    check("b_no_autostart",  64'(b_busy),         64'd0);
    wait_a_done();
    bad = 0;
    for (int j = 0; j < 16; j++) if (a_seen[j] !== rom_word(32'(j))) bad++;
    check("a_seed_valid_cycles", 64'(a_nseen), 64'd16);
    check("a_seed_valid_bursts", 64'(a_nrise), 64'd1);
    check("a_seed_words_bad",    64'(bad),     64'd0);
    check("a_phase_cyc",   a_phase_cyc,          {32'd250, 32'd100});
    check("a_cyc_total",   64'(a_cyc_total),     64'd300);
    check("a_cyc_sum",     64'(a_cyc_sum),       64'd300);
    check("a_run_idx",     64'(a_run_idx),       64'd1);
    check("a_led",         64'(a_led),           64'd1);
    check("a_timeout_err", 64'(a_timeout_err),   64'd0);
    check("a_busy_fin",    64'(a_busy),          64'd0);

    // Second batch on a: phase 1 never, phase 0 and core_done together at 40.
    a_p0 = 40; a_p1 = NEVER; a_done = 40;
    a_start = 1'b1; tick(); a_start = 1'b0;
    tick();
    check("a_b2_busy",     64'(a_busy),     64'd1);
    check("a_b2_all_done", 64'(a_all_done), 64'd0);
    wait_a_done();
    check("a_b2_phase_cyc", a_phase_cyc,      {32'hFFFF_FFFF, 32'd40});
    check("a_b2_cyc_total", 64'(a_cyc_total), 64'd40);
    check("a_b2_cyc_sum",   64'(a_cyc_sum),   64'd40);
    check("a_b2_run_idx",   64'(a_run_idx),   64'd1);
    check("a_b2_nseen",     64'(a_nseen),     64'd16);

    // b: three runs at 50/60/70 with a stray start during run 1.
    // Between runs core_rst is high for NEXT (1) + CRST (4) = 5 cycles.
    b_done0 = 50; b_step = 10;
    b_start = 1'b1; tick(); b_start = 1'b0;
    n = 0; seen = 0; streak = 0; nstr = 0; s0 = 0; s1 = 0;
    while (!b_all_done && n < 3000) begin
      b_start = (n == 30);
      tick(); n++;
      if (b_bus.seed_valid) seen = 1;
      if (b_bus.core_rst && seen != 0) streak++;
      else if (streak != 0) begin
        if (nstr == 0) s0 = streak; else s1 = streak;
        nstr++; streak = 0;
      end
    end
    b_start = 1'b0;
    check("b3_all_done",   64'(b_all_done),  64'd1);
    check("b3_gaps",       64'(nstr),        64'd2);
    check("b3_gap0",       64'(s0),          64'd5);
    check("b3_gap1",       64'(s1),          64'd5);
    check("b3_run_idx",    64'(b_run_idx),   64'd3);
    check("b3_cyc_sum",    64'(b_cyc_sum),   64'd180);
    check("b3_cyc_total",  64'(b_cyc_total), 64'd70);
    check("b3_phase_cyc",  b_phase_cyc,      64'hFFFF_FFFF_FFFF_FFFF);
    check("b3_led",        64'(b_led),       64'd1);

    // b: timeout, core_done never rises. Count 1000 is reached k=1000 cycles
    // after the first seed_valid; the flag shows one cycle later.
    b_done0 = NEVER; b_step = 0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    n = 0; k = -1; tk = -1;
    while (!b_all_done && n < 3000) begin
      tick(); n++;
      if (k >= 0) k++;
      else if (b_bus.seed_valid) k = 0;
      if (b_timeout_err && tk < 0) tk = k;
    end
    check("bto_at_count",  64'(tk),           64'd1001);
    check("bto_err",       64'(b_timeout_err), 64'd1);
    check("bto_cyc_total", 64'(b_cyc_total),  64'hFFFF_FFFF);
    check("bto_all_done",  64'(b_all_done),   64'd1);
    check("bto_led",       64'(b_led),        64'd0);
    check("bto_run_idx",   64'(b_run_idx),    64'd0);
    check("bto_cyc_sum",   64'(b_cyc_sum),    64'd0);

    // b: rst in the middle of WAIT, then a clean batch.
    b_done0 = 500; b_step = 0;
    b_start = 1'b1; tick(); b_start = 1'b0;
    n = 0;
    while (!b_bus.seed_valid && n < 100) begin tick(); n++; end
    repeat (100) tick();
    check("bmid_busy", 64'(b_busy), 64'd1);
    rst = 1'b1; tick();
    check_b_reset_vals("bmid_rst");
    rst = 1'b0;
    repeat (10) tick();
    check("bpost_idle_busy",     64'(b_busy),         64'd0);
    check("bpost_idle_core_rst", 64'(b_bus.core_rst), 64'd1);
    b_done0 = 50; b_step = 10;
    b_start = 1'b1; tick(); b_start = 1'b0;
    wait_b_done();
    check("bclean_run_idx",   64'(b_run_idx),     64'd3);
    check("bclean_cyc_sum",   64'(b_cyc_sum),     64'd180);
    check("bclean_cyc_total", 64'(b_cyc_total),   64'd70);
    check("bclean_timeout",   64'(b_timeout_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
